// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the memory-mapped UART transmitter.
package uart_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

endpackage

// File: rtl/uart_tx_periph_fifo.sv
// Synchronous FIFO with first-word-fall-through output; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: DATA/STATUS/DIVISOR/CTRL registers, TX FIFO and serializer.
// Optional parity support is enabled by defining UART_TX_PARITY_EN.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter logic [31:0] BASEADDR    = 32'h0000_4000,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd347
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        ren,
    input  logic        wen,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        active,
    output logic        txd
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t      state;
    logic [15:0]    baud_cnt;
    logic [15:0]    divisor;
    logic [7:0]     shift_reg;
    logic [2:0]     bit_idx;
    logic           overflow;
    logic           bit_end;
    logic           pop_now;
    logic           busy;
    logic           wr_hit;
    logic           rd_hit;
    logic [1:0]     reg_sel;
    logic           fifo_push;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_dout;
    logic [CW-1:0]  fifo_count;
    logic [31:0]    status_word;
    logic [31:0]    ctrl_word;
    logic [31:0]    read_word;
    logic           unused_bits;

`ifdef UART_TX_PARITY_EN
    logic parity_en;
    logic parity_odd;
    logic frame_par_en;
    logic frame_par;
    assign ctrl_word = {30'h0, parity_odd, parity_en};
`else
    assign ctrl_word = 32'h0;
`endif

    assign active      = (addr[31:4] == BASEADDR[31:4]);
    assign wr_hit      = active && wen;
    assign rd_hit      = active && ren && !wen;
    assign reg_sel     = addr[3:2];
    assign fifo_push   = wr_hit && (reg_sel == REG_DATA) && wmask[0] && !fifo_full;
    assign bit_end     = (baud_cnt == 16'd0);
    assign busy        = (state != IDLE);
    assign pop_now     = !fifo_empty && ((state == IDLE) || (state == STOP && bit_end));
    assign status_word = {16'h0, 8'(fifo_count), 4'h0, overflow, busy, fifo_empty, fifo_full};
    assign unused_bits = &{1'b0, wdata[31:16], wmask[3:2], addr[1:0]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (pop_now),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        read_word = 32'h0;
        case (reg_sel)
            REG_STATUS:  read_word = status_word;
            REG_DIVISOR: read_word = {16'h0, divisor};
            REG_CTRL:    read_word = ctrl_word;
            default:     read_word = 32'h0;
        endcase
    end

    // Bus side: rdata only updates on an accepted read, so it holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready    <= 1'b0;
            rdata    <= 32'h0;
            divisor  <= DEFAULT_DIV;
            overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_en  <= 1'b0;
            parity_odd <= 1'b0;
`endif
        end else begin
            ready <= active && (ren || wen);
            if (rd_hit) begin
                rdata <= read_word;
            end
            if (wr_hit) begin
                case (reg_sel)
                    REG_DATA: begin
                        if (wmask[0] && fifo_full) overflow <= 1'b1;
                    end
                    REG_STATUS: begin
                        if (wmask[0] && wdata[ST_OVERFLOW]) overflow <= 1'b0;
                    end
                    REG_DIVISOR: begin
                        if (wmask[0]) divisor[7:0]  <= wdata[7:0];
                        if (wmask[1]) divisor[15:8] <= wdata[15:8];
                    end
                    default: begin
`ifdef UART_TX_PARITY_EN
                        if (wmask[0]) begin
                            parity_en  <= wdata[0];
                            parity_odd <= wdata[1];
                        end
`endif
                    end
                endcase
            end
        end
    end

    // Serializer: a pop at the end of STOP starts the next frame with no idle gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            txd       <= 1'b1;
            baud_cnt  <= 16'd0;
            shift_reg <= 8'h0;
            bit_idx   <= 3'd0;
`ifdef UART_TX_PARITY_EN
            frame_par_en <= 1'b0;
            frame_par    <= 1'b0;
`endif
        end else if (pop_now) begin
            state     <= START;
            txd       <= 1'b0;
            shift_reg <= fifo_dout;
            baud_cnt  <= divisor;
`ifdef UART_TX_PARITY_EN
            frame_par_en <= parity_en;
            frame_par    <= (^fifo_dout) ^ parity_odd;
`endif
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        txd      <= shift_reg[0];
                        bit_idx  <= 3'd0;
                        baud_cnt <= divisor;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= divisor;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            if (frame_par_en) begin
                                state <= PARITY;
                                txd   <= frame_par;
                            end else begin
                                state <= STOP;
                                txd   <= 1'b1;
                            end
`else
                            state <= STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= shift_reg >> 1;
                            txd       <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        txd      <= 1'b1;
                        baud_cnt <= divisor;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        txd   <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Scoreboard bench for uart_tx_periph: bytes written are queued and checked by a txd receiver.
module tb_uart_tx_periph;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wmask = 4'h0;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] rdata;
    logic        ready;
    logic        active;
    logic        txd;

    int     test_count = 0;
    int     fail_count = 0;
    int     cur_div = 347;
    frame_t exp_q[$];

    int         mon_t;
    int         mon_p;
    int         mon_last;
    int         mon_k;
    bit         mon_busy = 1'b0;
    bit         mon_has;
    frame_t     mon_exp;
    logic [7:0] mon_byte;
    logic       mon_parv;

    uart_tx_periph dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .wdata  (wdata),
        .wmask  (wmask),
        .ren    (ren),
        .wen    (wen),
        .rdata  (rdata),
        .ready  (ready),
        .active (active),
        .txd    (txd)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(posedge clk); #1;
        addr = a; wdata = d; wmask = m; wen = 1'b1;
        @(posedge clk); #1;
        wen = 1'b0;
        checkOutput("wr_ready", ready, 1);
    endtask

    task automatic busRead(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        addr = a; ren = 1'b1;
        @(posedge clk); #1;
        ren = 1'b0;
        checkOutput("rd_ready", ready, 1);
        d = rdata;
    endtask

    task automatic readCheck(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        busRead(a, d);
        checkOutput(tag, d, exp);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic pen, input logic odd);
        frame_t f;
        f.data = b;
        f.par_en = pen;
        f.par = (^b) ^ odd;
        exp_q.push_back(f);
        busWrite(32'h4000, {24'h0, b}, 4'h1);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drain", exp_q.size(), 0);
    endtask

    // Receiver: samples txd mid-bit on falling clock edges, frame length from the expected entry.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_busy = 1'b0;
        end else begin
            if (!mon_busy && txd === 1'b0) begin
                mon_busy = 1'b1;
                mon_t    = 0;
                mon_p    = cur_div + 1;
                mon_has  = (exp_q.size() > 0);
                if (mon_has) mon_exp = exp_q[0];
                mon_last = (mon_has && mon_exp.par_en) ? 10 : 9;
            end
            if (mon_busy) begin
                if ((mon_t % mon_p) == (mon_p / 2)) begin
                    mon_k = mon_t / mon_p;
                    if (mon_k == 0) checkOutput("start_bit", txd, 0);
                    else if (mon_k <= 8) mon_byte[mon_k-1] = txd;
                    else if (mon_k < mon_last) mon_parv = txd;
                    if (mon_k == mon_last) begin
                        checkOutput("stop_bit", txd, 1);
                        checkOutput("rx_expected", mon_has, 1);
                        if (mon_has) begin
                            void'(exp_q.pop_front());
                            checkOutput("rx_byte", mon_byte, mon_exp.data);
                            if (mon_exp.par_en) checkOutput("parity", mon_parv, mon_exp.par);
                        end
                        mon_busy = 1'b0;
                    end
                end
                mon_t++;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus();
        logic [31:0] d;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_txd", txd, 1);
        checkOutput("rst_ready", ready, 0);
        checkOutput("rst_rdata", rdata, 0);
        rst_n = 1'b1;

        readCheck("status_reset", 32'h4004, 32'h0000_0002);
        @(posedge clk); #1;
        checkOutput("ready_one_cycle", ready, 0);
        checkOutput("txd_idle", txd, 1);
        readCheck("div_reset", 32'h4008, 32'd347);
        readCheck("ctrl_reset", 32'h400C, 32'h0);

        busWrite(32'h4008, 32'h0000_0003, 4'h3);
        cur_div = 3;
        readCheck("div_set", 32'h4008, 32'd3);
        busWrite(32'h4004, 32'h0, 4'h0);
        checkOutput("rdata_hold", rdata, 32'd3);
        sendByte(8'h55, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        busRead(32'h4004, d);
        checkOutput("busy_mid_frame", d[2], 1);
        waitDrain(200);
        repeat (6) @(posedge clk);
        readCheck("status_idle", 32'h4004, 32'h0000_0002);

        busWrite(32'h4008, 32'h0000_FF05, 4'h1);
        readCheck("div_bytemask", 32'h4008, 32'd5);
        busWrite(32'h4008, 32'h0, 4'h3);
        cur_div = 0;
        readCheck("data_reads0", 32'h4000, 32'h0);
        busWrite(32'h4000, 32'h0000_0099, 4'hE);
        readCheck("nomask_nopush", 32'h4004, 32'h0000_0002);

        sendByte(8'hA3, 1'b0, 1'b0);
        sendByte(8'h3C, 1'b0, 1'b0);
        sendByte(8'hFF, 1'b0, 1'b0);
        sendByte(8'h00, 1'b0, 1'b0);
        sendByte(8'h81, 1'b0, 1'b0);
        waitDrain(300);

        @(posedge clk); #1;
        addr = 32'h4010; wdata = 32'h0000_0077; wmask = 4'hF; wen = 1'b1; ren = 1'b1;
        #1;
        checkOutput("active_oob", active, 0);
        @(posedge clk); #1;
        wen = 1'b0; ren = 1'b0;
        checkOutput("oob_no_ready", ready, 0);
        addr = 32'h3FFC; #1;
        checkOutput("active_below", active, 0);
        addr = 32'h400C; #1;
        checkOutput("active_top", active, 1);
        readCheck("oob_fifo_same", 32'h4004, 32'h0000_0002);

        @(posedge clk); #1;
        addr = 32'h4008; wdata = 32'h0000_0007; wmask = 4'h3; wen = 1'b1; ren = 1'b1;
        @(posedge clk); #1;
        wen = 1'b0; ren = 1'b0;
        checkOutput("rw_ready", ready, 1);
        readCheck("rw_is_write", 32'h4008, 32'd7);
        busWrite(32'h4008, 32'h0, 4'h3);

`ifdef UART_TX_PARITY_EN
        busWrite(32'h400C, 32'h1, 4'h1);
        readCheck("ctrl_even", 32'h400C, 32'h1);
        sendByte(8'h07, 1'b1, 1'b0);
        waitDrain(100);
        busWrite(32'h400C, 32'h3, 4'h1);
        readCheck("ctrl_odd", 32'h400C, 32'h3);
        sendByte(8'h07, 1'b1, 1'b1);
        waitDrain(100);
        busWrite(32'h400C, 32'h0, 4'h1);
`else
        busWrite(32'h400C, 32'h3, 4'h1);
        readCheck("ctrl_absent", 32'h400C, 32'h0);
`endif

        busWrite(32'h4008, 32'd1000, 4'h3);
        cur_div = 1000;
        for (int i = 0; i < 17; i++) begin
            sendByte(8'(i + 8'h10), 1'b0, 1'b0);
        end
        readCheck("status_full", 32'h4004, 32'h0000_1005);
        busWrite(32'h4000, 32'h0000_00EE, 4'h1);
        readCheck("status_overflow", 32'h4004, 32'h0000_100D);
        busWrite(32'h4004, 32'h0000_0008, 4'h1);
        readCheck("overflow_clear", 32'h4004, 32'h0000_1005);

        checkOutput("txd_in_start", txd, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_txd", txd, 1);
        exp_q.delete();
        cur_div = 347;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        readCheck("status_after_rst", 32'h4004, 32'h0000_0002);
        readCheck("div_after_rst", 32'h4008, 32'd347);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("txd_quiet", txd, 1);
    endtask

    initial begin
        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
